pow5_result_serializer: RTL and testbench
=========================================

// Module: pow5_result_serializer
// PURPOSE
//  Downstream consumer of pow5_pipelined_valid. Captures each POW*DATA_WIDTH-bit result
//  strobed by data_valid_i into a small FIFO. Replays every result as POW DATA_WIDTH-bit
//  chunks, LSB chunk first, over a valid/ready stream toward the byte-wide output path.
//  Absorbs result bursts, because the pow5 pipeline has no backpressure input.
// PARAMETERS
//  DATA_WIDTH  8  operand width of the pow stage; also the width of each output chunk
//  POW         5  exponent; input result width = POW*DATA_WIDTH; chunks per word = POW
//  FIFO_DEPTH  4  result FIFO entries; power of two, >= 2
// PORTS
//  clk_i          in   1                  clock, rising edge
//  rst_i          in   1                  asynchronous reset, active-high
//  pow_data_i     in   POW*DATA_WIDTH     result word from the pow stage
//  data_valid_i   in   1                  pow_data_i valid this cycle
//  ser_data_o     out  DATA_WIDTH         current output chunk
//  ser_valid_o    out  1                  ser_data_o valid
//  ser_ready_i    in   1                  sink accepts the chunk when valid&ready
//  ser_last_o     out  1                  current chunk is the last (MS) chunk of its word
//  fifo_count_o   out  $clog2(FIFO_DEPTH+1)  words held in the FIFO (excludes shift reg)
//  overflow_o     out  1                  sticky: a result was dropped
//  clr_overflow_i in   1                  synchronous clear of overflow_o
// BEHAVIOUR
//  Reset (async, rst_i=1): ser_valid_o=0, ser_last_o=0, ser_data_o=0, fifo_count_o=0,
//   overflow_o=0, FSM=IDLE, chunk index=0, FIFO pointers=0. Takes effect immediately,
//   not on the next edge. A partially sent word is discarded.
//  Write: push = data_valid_i & (!full | pop); pop = FIFO read in the same cycle.
//   With data_valid_i & full & !pop, the word is dropped and overflow_o<=1.
//   overflow_o stays set until clr_overflow_i or reset. When clr and a new drop coincide,
//   the drop wins and overflow_o stays 1.
//  FSM: 2 states, IDLE and SEND. The shift register holds the word being sent.
//   IDLE: if FIFO non-empty -> pop into shift reg, idx<=0, go SEND.
//   SEND: ser_valid_o=1; ser_data_o=shift_reg[idx*DATA_WIDTH +: DATA_WIDTH].
//    On ready & idx<POW-1: idx<=idx+1.
//    On ready & idx==POW-1: if FIFO non-empty -> pop, reload, idx<=0, stay SEND
//     (no bubble between words); else go IDLE.
//  ser_last_o = ser_valid_o & (idx==POW-1).
//  While valid & !ready, ser_data_o and ser_last_o are held stable.
//  Latency: a word sampled at edge N into an empty FIFO, with FSM in IDLE, is popped at
//   edge N+1. Its first chunk is valid after edge N+1.
//  Capacity while the sink stalls: FIFO_DEPTH words plus 1 word in the shift reg.
//  fifo_count_o: +1 on push, -1 on pop, unchanged when push and pop coincide.
//   Never exceeds FIFO_DEPTH.
//  FIFO pointers wrap modulo FIFO_DEPTH; full/empty are decoded from the count.
//  Word order out equals word order in; no reordering, no duplication.
// TESTING
//  1. Push 3 (0x00000000F3), ready=1 -> chunks F3,00,00,00,00; last on 5th; valid drops.
//  2. Push 16807 (0x00000041A7) and 255^5 (0xFB09F604FF) back-to-back ->
//     A7,41,00,00,00 then FF,04,F6,09,FB, with no idle cycle between the two words.
//  3. Word 0xFB09F604FF, ready low 3 cycles after chunk 2 is shown -> ser_data_o holds
//     0xF6 and ser_last_o holds 0 for all 3 cycles; stream then resumes 09,FB.
//  4. FIFO_DEPTH=4, ready=0, push 6 words 1..6 -> fifo_count_o=4, overflow_o=1.
//     Release ready -> words 1..5 delivered in order; 6 never appears.
//     Pulse clr_overflow_i -> overflow_o=0.
//  5. Reset asserted mid-word (after 2 chunks accepted) -> ser_valid_o=0 at once,
//     fifo_count_o=0. After release, a push of 2 (0x20) yields 20,00,00,00,00 only.
//  6. FIFO full with the last chunk accepted in the same cycle as a new data_valid_i ->
//     the word is stored, overflow_o stays 0, fifo_count_o stays 4.

Source files
------------

// File: rtl/pow5_result_serializer.sv
`default_nettype none
// ============================================================================
// Module  : pow5_result_serializer
// Brief   : Buffers POW*DATA_WIDTH-bit pow results in a small FIFO and replays
//           each one as POW chunks, LSB chunk first, over a valid/ready stream.
// Revision: 1.0 - initial release
// ============================================================================
module pow5_result_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int POW        = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [POW*DATA_WIDTH-1:0]        pow_data_i,
  input  logic                             data_valid_i,
  output logic [DATA_WIDTH-1:0]            ser_data_o,
  output logic                             ser_valid_o,
  input  logic                             ser_ready_i,
  output logic                             ser_last_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count_o,
  output logic                             overflow_o,
  input  logic                             clr_overflow_i
);

  localparam int c_WORD_W = POW * DATA_WIDTH;
  localparam int c_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int c_IDX_W  = (POW > 1) ? $clog2(POW) : 1;
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(POW - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t                 state_q,    state_d;
  logic [c_IDX_W-1:0]     idx_q,      idx_d;
  logic [c_WORD_W-1:0]    shift_q,    shift_d;
  logic [c_PTR_W-1:0]     wr_ptr_q,   wr_ptr_d;
  logic [c_PTR_W-1:0]     rd_ptr_q,   rd_ptr_d;
  logic [c_CNT_W-1:0]     count_q,    count_d;
  logic                   overflow_q, overflow_d;
  logic [c_WORD_W-1:0]    mem_q [FIFO_DEPTH];

  logic w_empty, w_full, w_accept, w_at_last, w_pop, w_push, w_drop;

  assign w_empty   = (count_q == '0);
  assign w_full    = (count_q == c_CNT_FULL);
  assign w_accept  = (state_q == ST_SEND) && ser_ready_i;
  assign w_at_last = (idx_q == c_IDX_LAST);
  // A pop refills the shift register either from idle or right as the last
  // chunk leaves, so consecutive words stream without a bubble.
  assign w_pop     = !w_empty && ((state_q == ST_IDLE) || (w_accept && w_at_last));
  assign w_push    = data_valid_i && (!w_full || w_pop);
  assign w_drop    = data_valid_i && w_full && !w_pop;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (w_pop) begin
          shift_d = mem_q[rd_ptr_q];
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_accept) begin
          if (!w_at_last) begin
            idx_d = idx_q + 1'b1;
          end else if (w_pop) begin
            shift_d = mem_q[rd_ptr_q];
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A fresh drop outranks a clear issued in the same cycle.
    if (w_drop)              overflow_d = 1'b1;
    else if (clr_overflow_i) overflow_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) mem_q[wr_ptr_q] <= pow_data_i;
  end

  assign ser_valid_o  = (state_q == ST_SEND);
  assign ser_data_o   = ser_valid_o ? shift_q[idx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign ser_last_o   = ser_valid_o && w_at_last;
  assign fifo_count_o = count_q;
  assign overflow_o   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_pow5_result_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pow5_result_serializer
// Brief   : Scoreboard bench for pow5_result_serializer (DATA_WIDTH=8, POW=5,
//           FIFO_DEPTH=4); expected chunks are queued as words are driven.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pow5_result_serializer;

  localparam int DW    = 8;
  localparam int POW   = 5;
  localparam int DEPTH = 4;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic [POW*DW-1:0] pow_data_i = '0;
  logic              data_valid_i = 1'b0;
  logic [DW-1:0]     ser_data_o;
  logic              ser_valid_o;
  logic              ser_ready_i = 1'b0;
  logic              ser_last_o;
  logic [2:0]        fifo_count_o;
  logic              overflow_o;
  logic              clr_overflow_i = 1'b0;

  logic [8:0] exp_q [$];
  logic [8:0] mon_exp;
  int n_cmp = 0;
  int n_err = 0;

  pow5_result_serializer #(
    .DATA_WIDTH (DW),
    .POW        (POW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .pow_data_i     (pow_data_i),
    .data_valid_i   (data_valid_i),
    .ser_data_o     (ser_data_o),
    .ser_valid_o    (ser_valid_o),
    .ser_ready_i    (ser_ready_i),
    .ser_last_o     (ser_last_o),
    .fifo_count_o   (fifo_count_o),
    .overflow_o     (overflow_o),
    .clr_overflow_i (clr_overflow_i)
  );

  always #5 clk_i = ~clk_i;

  // Every handshake is checked against the oldest expected chunk.
  always @(negedge clk_i) begin
    if (!rst_i && ser_valid_o && ser_ready_i) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL chunk_unexpected: got last=%b data=%h, required no chunk", ser_last_o, ser_data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({ser_last_o, ser_data_o} !== mon_exp) begin
          n_err++;
          $display("FAIL chunk: got last=%b data=%h, required last=%b data=%h",
                   ser_last_o, ser_data_o, mon_exp[8], mon_exp[7:0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_word(input logic [POW*DW-1:0] w, input bit stored);
    if (stored) begin
      for (int k = 0; k < POW; k++) exp_q.push_back({(k == POW-1), w[k*DW +: DW]});
    end
    data_valid_i = 1'b1;
    pow_data_i   = w;
    tick();
    data_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || ser_valid_o) && k < budget) begin
      tick();
      k++;
    end
    n_cmp++;
    if (k >= budget) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d chunks outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!ser_valid_o && k < budget) begin
      tick();
      k++;
    end
    n_cmp++;
    if (!ser_valid_o) begin
      n_err++;
      $display("FAIL valid_timeout: got valid=%b, required 1", ser_valid_o);
    end
  endtask

  task automatic test_reset;
    #1 rst_i = 1'b1;
    #1;
    n_cmp++; if (ser_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, required 0", ser_valid_o); end
    n_cmp++; if (ser_last_o !== 1'b0) begin n_err++; $display("FAIL rst_last: got %b, required 0", ser_last_o); end
    n_cmp++; if (ser_data_o !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h, required 00", ser_data_o); end
    n_cmp++; if (fifo_count_o !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d, required 0", fifo_count_o); end
    n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b, required 0", overflow_o); end
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_single;
    ser_ready_i = 1'b1;
    push_word(40'h00000000F3, 1'b1);
    n_cmp++; if (fifo_count_o !== 3'd1 || ser_valid_o !== 1'b0) begin
      n_err++; $display("FAIL single_latency0: got count=%0d valid=%b, required count=1 valid=0", fifo_count_o, ser_valid_o);
    end
    tick();
    n_cmp++; if (ser_valid_o !== 1'b1 || ser_data_o !== 8'hF3 || fifo_count_o !== 3'd0) begin
      n_err++; $display("FAIL single_latency1: got valid=%b data=%h count=%0d, required 1 F3 0", ser_valid_o, ser_data_o, fifo_count_o);
    end
    wait_idle(40);
    n_cmp++; if (ser_valid_o !== 1'b0 || ser_last_o !== 1'b0) begin
      n_err++; $display("FAIL single_end: got valid=%b last=%b, required 0 0", ser_valid_o, ser_last_o);
    end
  endtask

  task automatic test_back_to_back;
    ser_ready_i = 1'b1;
    push_word(40'h00000041A7, 1'b1);
    push_word(40'hFB09F604FF, 1'b1);
    for (int i = 0; i < 2*POW; i++) begin
      @(negedge clk_i);
      n_cmp++;
      if (ser_valid_o !== 1'b1) begin
        n_err++; $display("FAIL b2b_bubble: chunk %0d got valid=%b, required 1", i, ser_valid_o);
      end
    end
    @(negedge clk_i);
    n_cmp++; if (ser_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_end: got valid=%b, required 0", ser_valid_o); end
    wait_idle(40);
  endtask

  task automatic test_stall_hold;
    ser_ready_i = 1'b0;
    push_word(40'hFB09F604FF, 1'b1);
    wait_valid(10);
    ser_ready_i = 1'b1;
    tick();
    tick();
    ser_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      n_cmp++;
      if (ser_valid_o !== 1'b1 || ser_data_o !== 8'hF6 || ser_last_o !== 1'b0) begin
        n_err++; $display("FAIL stall_hold: cycle %0d got valid=%b data=%h last=%b, required 1 F6 0",
                          i, ser_valid_o, ser_data_o, ser_last_o);
      end
      tick();
    end
    ser_ready_i = 1'b1;
    wait_idle(40);
  endtask

  task automatic test_overflow;
    ser_ready_i = 1'b0;
    for (int w = 1; w <= 6; w++) push_word(40'(w), (w <= 5));
    n_cmp++; if (fifo_count_o !== 3'd4) begin n_err++; $display("FAIL ovf_count: got %0d, required 4", fifo_count_o); end
    n_cmp++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b, required 1", overflow_o); end
    ser_ready_i = 1'b1;
    wait_idle(100);
    n_cmp++; if (fifo_count_o !== 3'd0) begin n_err++; $display("FAIL ovf_drained: got %0d, required 0", fifo_count_o); end
    n_cmp++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b, required 1", overflow_o); end
    clr_overflow_i = 1'b1;
    tick();
    clr_overflow_i = 1'b0;
    n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b, required 0", overflow_o); end
  endtask

  task automatic test_reset_mid_word;
    ser_ready_i = 1'b0;
    push_word(40'h0504030201, 1'b1);
    push_word(40'h1111111111, 1'b1);
    wait_valid(10);
    ser_ready_i = 1'b1;
    tick();
    tick();
    ser_ready_i = 1'b0;
    n_cmp++; if (fifo_count_o !== 3'd1) begin n_err++; $display("FAIL midrst_pre_count: got %0d, required 1", fifo_count_o); end
    #1 rst_i = 1'b1;
    #1;
    n_cmp++; if (ser_valid_o !== 1'b0 || ser_data_o !== 8'h00 || ser_last_o !== 1'b0) begin
      n_err++; $display("FAIL midrst_outputs: got valid=%b data=%h last=%b, required 0 00 0", ser_valid_o, ser_data_o, ser_last_o);
    end
    n_cmp++; if (fifo_count_o !== 3'd0) begin n_err++; $display("FAIL midrst_count: got %0d, required 0", fifo_count_o); end
    exp_q.delete();
    tick();
    rst_i = 1'b0;
    ser_ready_i = 1'b1;
    push_word(40'h0000000020, 1'b1);
    wait_idle(40);
  endtask

  task automatic test_full_pop_push;
    ser_ready_i = 1'b0;
    for (int w = 0; w < 5; w++) push_word(40'hA0_0000_0000 + 40'(w), 1'b1);
    n_cmp++; if (fifo_count_o !== 3'd4 || ser_valid_o !== 1'b1) begin
      n_err++; $display("FAIL fpp_pre: got count=%0d valid=%b, required 4 1", fifo_count_o, ser_valid_o);
    end
    ser_ready_i = 1'b1;
    repeat (POW-1) tick();
    n_cmp++; if (ser_last_o !== 1'b1) begin n_err++; $display("FAIL fpp_last: got %b, required 1", ser_last_o); end
    push_word(40'hA0_0000_0005, 1'b1);
    ser_ready_i = 1'b0;
    n_cmp++; if (fifo_count_o !== 3'd4) begin n_err++; $display("FAIL fpp_count: got %0d, required 4", fifo_count_o); end
    n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL fpp_overflow: got %b, required 0", overflow_o); end
    ser_ready_i = 1'b1;
    wait_idle(100);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall_hold();
    test_overflow();
    test_reset_mid_word();
    test_full_pop_push();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL leftover: got %0d expected chunks unsent, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
